// File: rtl/neuron_sample_feeder.sv
// neuron_sample_feeder: buffers a training set of (X1, X2, t) samples from a
// loader and streams them to the neuron, one per readyToGetData handshake,
// wrapping to sample 0 at every epoch end until the neuron reports done.
module neuron_sample_feeder #(
    parameter int DEPTH = 501,
    parameter int X_W   = 7,
    parameter int T_W   = 2,
    parameter int N_W   = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    input  logic [X_W-1:0] load_x1,
    input  logic [X_W-1:0] load_x2,
    input  logic [T_W-1:0] load_t,
    output logic           load_ready,
    input  logic           clear,
    input  logic           go,
    output logic           go_err,
    output logic           start,
    output logic [N_W-1:0] nBus,
    output logic [X_W-1:0] X1Bus,
    output logic [X_W-1:0] X2Bus,
    output logic [T_W-1:0] tBus,
    input  logic           readyToGetData,
    input  logic           done,
    output logic           busy,
    output logic [CW-1:0]  count,
    output logic [15:0]    epoch
);

    localparam int SW = 2 * X_W + T_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        FEED  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;

    // Sample storage; contents deliberately survive reset.
    logic [SW-1:0]  mem_r [DEPTH];

    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_nxt_s;
    logic [CW-1:0]  rd_idx_r;
    logic [CW-1:0]  rd_idx_nxt_s;
    logic [N_W-1:0] nbus_r;
    logic [SW-1:0]  bus_r;
    logic [15:0]    epoch_r;
    logic           start_r;
    logic           go_err_r;

    logic           we_s;
    logic           go_ok_s;
    logic           go_bad_s;
    logic           consume_s;
    logic           wrap_s;
    logic [SW-1:0]  load_word_s;
    logic [SW-1:0]  head_word_s;
    logic [SW-1:0]  rd_word_s;

    assign load_word_s = {load_x1, load_x2, load_t};
    assign load_ready  = (state_r == IDLE) && (count_r < DEPTH_C);

    // Loader side: write enable, next count and go qualification; a load in
    // the same cycle as go commits first, so go judges the updated count.
    always_comb begin
        we_s        = 1'b0;
        count_nxt_s = count_r;
        go_ok_s     = 1'b0;
        go_bad_s    = 1'b0;
        if (state_r == IDLE) begin
            if (clear) begin
                count_nxt_s = '0;
            end else if (load_valid && load_ready) begin
                we_s        = 1'b1;
                count_nxt_s = count_r + CW'(1);
            end else begin
                count_nxt_s = count_r;
            end
            if (go) begin
                if (count_nxt_s != '0) begin
                    go_ok_s = 1'b1;
                end else begin
                    go_bad_s = 1'b1;
                end
            end else begin
                go_ok_s  = 1'b0;
                go_bad_s = 1'b0;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Feed side: consume qualification, index wrap and the words to present.
    // Sample 0 is bypassed from the load port when it is written on the go edge.
    always_comb begin
        consume_s = (state_r == FEED) && readyToGetData && !done;
        wrap_s    = (rd_idx_r == (count_r - CW'(1)));
        if (wrap_s) begin
            rd_idx_nxt_s = '0;
        end else begin
            rd_idx_nxt_s = rd_idx_r + CW'(1);
        end
        rd_word_s = mem_r[rd_idx_nxt_s];
        if (we_s && (count_r == '0)) begin
            head_word_s = load_word_s;
        end else begin
            head_word_s = mem_r[0];
        end
    end

    // Next-state logic for the IDLE -> START -> FEED run sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (go_ok_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                state_nxt_s = FEED;
            end
            FEED: begin
                if (done) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FEED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample buffer write port.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[count_r] <= load_word_s;
        end
    end

    // Count, run parameters, sample buses and epoch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= '0;
            start_r  <= 1'b0;
            go_err_r <= 1'b0;
            nbus_r   <= '0;
            rd_idx_r <= '0;
            bus_r    <= '0;
            epoch_r  <= 16'd0;
        end else begin
            count_r  <= count_nxt_s;
            start_r  <= go_ok_s;
            go_err_r <= go_bad_s;
            if (go_ok_s) begin
                nbus_r   <= N_W'(count_nxt_s);
                rd_idx_r <= '0;
                bus_r    <= head_word_s;
                epoch_r  <= 16'd0;
            end else if (consume_s) begin
                rd_idx_r <= rd_idx_nxt_s;
                bus_r    <= rd_word_s;
                if (wrap_s && (epoch_r != 16'hFFFF)) begin
                    epoch_r <= epoch_r + 16'd1;
                end
            end
        end
    end

    assign start  = start_r;
    assign go_err = go_err_r;
    assign nBus   = nbus_r;
    assign X1Bus  = bus_r[SW-1 -: X_W];
    assign X2Bus  = bus_r[T_W +: X_W];
    assign tBus   = bus_r[T_W-1:0];
    assign busy   = (state_r != IDLE);
    assign count  = count_r;
    assign epoch  = epoch_r;

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Directed bench for neuron_sample_feeder: expected bus words are queued when
// a consume/go is driven and popped for comparison after the clock edge.
module tb_neuron_sample_feeder;

    localparam int DEPTH = 501;
    localparam int X_W   = 7;
    localparam int T_W   = 2;
    localparam int N_W   = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk;
    logic           rst;
    logic           load_valid;
    logic [X_W-1:0] load_x1;
    logic [X_W-1:0] load_x2;
    logic [T_W-1:0] load_t;
    logic           load_ready;
    logic           clear;
    logic           go;
    logic           go_err;
    logic           start;
    logic [N_W-1:0] nBus;
    logic [X_W-1:0] X1Bus;
    logic [X_W-1:0] X2Bus;
    logic [T_W-1:0] tBus;
    logic           readyToGetData;
    logic           done;
    logic           busy;
    logic [CW-1:0]  count;
    logic [15:0]    epoch;

    int total;
    int bad;
    logic [15:0] sb_q[$];
    logic [15:0] smp[3];
    logic [15:0] one_s;
    int mi;
    int mep;

    neuron_sample_feeder #(.DEPTH(DEPTH), .X_W(X_W), .T_W(T_W), .N_W(N_W)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_x1(load_x1),
        .load_x2(load_x2), .load_t(load_t), .load_ready(load_ready),
        .clear(clear), .go(go), .go_err(go_err), .start(start), .nBus(nBus),
        .X1Bus(X1Bus), .X2Bus(X2Bus), .tBus(tBus),
        .readyToGetData(readyToGetData), .done(done), .busy(busy),
        .count(count), .epoch(epoch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sample(input logic [15:0] w);
        load_x1 = w[15:9];
        load_x2 = w[8:2];
        load_t  = w[1:0];
    endtask

    task automatic check_bus(input string tag);
        logic [15:0] e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=empty_queue expected=queued_word", tag);
        end else begin
            total--;
            e = sb_q.pop_front();
            chk(tag, {16'd0, X1Bus, X2Bus, tBus}, {16'd0, e});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        smp[0] = {7'b0000011, 7'b1111101, 2'b01};
        smp[1] = {7'b1110000, 7'b0010000, 2'b11};
        smp[2] = {7'b0000001, 7'b0000001, 2'b01};
        rst = 1'b1; load_valid = 1'b0; load_x1 = 7'd0; load_x2 = 7'd0; load_t = 2'd0;
        clear = 1'b0; go = 1'b0; readyToGetData = 1'b0; done = 1'b0;

        // Reset state
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_nbus", nBus, 32'd0);
        rst = 1'b0;
        tick();

        // Load three samples and start a run
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            drive_sample(smp[i]);
            tick();
        end
        load_valid = 1'b0;
        chk("load3_count", 32'(count), 32'd3);
        go = 1'b1;
        sb_q.push_back(smp[0]);
        tick();
        go = 1'b0;
        chk("go_start", 32'(start), 32'd1);
        chk("go_nbus", nBus, 32'd3);
        chk("go_busy", 32'(busy), 32'd1);
        check_bus("go_bus0");
        tick();
        chk("start_one_cycle", 32'(start), 32'd0);
        tick();

        // Seven consumes, one every second cycle
        mi = 0;
        mep = 0;
        for (int k = 0; k < 7; k++) begin
            readyToGetData = 1'b1;
            mi = (mi + 1) % 3;
            if (mi == 0) mep++;
            sb_q.push_back(smp[mi]);
            tick();
            readyToGetData = 1'b0;
            check_bus("consume_bus");
            chk("consume_epoch", 32'(epoch), 32'(mep));
            tick();
        end

        // done together with a consume mid-epoch
        readyToGetData = 1'b1;
        done = 1'b1;
        tick();
        readyToGetData = 1'b0;
        done = 1'b0;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_epoch", 32'(epoch), 32'd2);
        chk("done_count", 32'(count), 32'd3);
        sb_q.push_back(smp[1]);
        check_bus("done_bus_held");

        // Retrain from sample 0
        go = 1'b1;
        sb_q.push_back(smp[0]);
        tick();
        go = 1'b0;
        chk("rego_start", 32'(start), 32'd1);
        chk("rego_epoch", 32'(epoch), 32'd0);
        check_bus("rego_bus0");
        tick();
        readyToGetData = 1'b1;
        sb_q.push_back(smp[1]);
        tick();
        readyToGetData = 1'b0;
        check_bus("rego_bus1");

        // Reset in the middle of FEED
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_nbus", nBus, 32'd0);
        chk("midrst_bus", 32'({X1Bus, X2Bus, tBus}), 32'd0);
        chk("midrst_epoch", 32'(epoch), 32'd0);
        chk("midrst_load_ready", 32'(load_ready), 32'd1);

        // go with an empty buffer
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("goerr_pulse", 32'(go_err), 32'd1);
        chk("goerr_start", 32'(start), 32'd0);
        chk("goerr_busy", 32'(busy), 32'd0);
        tick();
        chk("goerr_one_cycle", 32'(go_err), 32'd0);
        chk("goerr_no_start", 32'(start), 32'd0);

        // clear wins over a simultaneous load
        load_valid = 1'b1;
        clear = 1'b1;
        drive_sample(smp[2]);
        tick();
        load_valid = 1'b0;
        clear = 1'b0;
        chk("clear_load_count", 32'(count), 32'd0);

        // Load and go in the same cycle, then stream a one-sample set
        one_s = {7'b1000000, 7'b0111111, 2'b10};
        load_valid = 1'b1;
        drive_sample(one_s);
        go = 1'b1;
        sb_q.push_back(one_s);
        tick();
        load_valid = 1'b0;
        go = 1'b0;
        chk("loadgo_start", 32'(start), 32'd1);
        chk("loadgo_nbus", nBus, 32'd1);
        chk("loadgo_count", 32'(count), 32'd1);
        check_bus("loadgo_bus");
        tick();
        readyToGetData = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sb_q.push_back(one_s);
            tick();
            check_bus("single_bus");
            chk("single_epoch", 32'(epoch), 32'(k));
        end
        readyToGetData = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("single_done_busy", 32'(busy), 32'd0);
        chk("single_done_epoch", 32'(epoch), 32'd4);

        // Fill past capacity
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            logic [15:0] w;
            w = {7'(i), ~7'(i), 2'(i)};
            load_valid = 1'b1;
            drive_sample(w);
            tick();
            if (i >= DEPTH - 2) begin
                chk("fill_load_ready", 32'(load_ready), 32'((i + 1) < DEPTH));
            end
        end
        load_valid = 1'b0;
        chk("fill_count", 32'(count), 32'(DEPTH));
        go = 1'b1;
        sb_q.push_back({7'd0, 7'h7f, 2'd0});
        tick();
        go = 1'b0;
        chk("fill_nbus", nBus, 32'(DEPTH));
        check_bus("fill_bus0");
        tick();
        readyToGetData = 1'b1;
        sb_q.push_back({7'd1, 7'h7e, 2'd1});
        tick();
        readyToGetData = 1'b0;
        check_bus("fill_bus1");
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("fill_done_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
